// File: rtl/ysyx_25060170_if_id_buf.sv
// IF->ID stage buffer: a DEPTH-entry FIFO of {inst, pc, pred_jump} beats
// between the fetch unit and the decoder. Handshakes on both sides, one
// flush input that empties the buffer, and registered outputs. With DEPTH>=2
// the buffer streams one beat per cycle; DEPTH=1 gives one beat every two cycles.
module ysyx_25060170_if_id_buf #(
    parameter int INST_W = 32,
    parameter int PC_W   = 32,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] in_inst,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              in_jump,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [PC_W-1:0]   out_pc,
    output logic              out_jump,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ENT_W = INST_W + PC_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [PTR_W-1:0] rd_nxt, wr_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [ENT_W-1:0] in_ent, head_q, head_nxt;
    logic             push, pop;

    // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign in_ent = {in_inst, in_pc, in_jump};

    // in_ready depends on registered occupancy only, never on out_ready.
    assign in_ready = (count != FULL);
    assign push     = in_valid & in_ready & ~flush;
    assign pop      = out_valid & out_ready & ~flush;

    assign {out_inst, out_pc, out_jump} = head_q;

    // Next pointers, occupancy and the head the output register will hold.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        rd_nxt   = pop  ? ptr_inc(rd_ptr) : rd_ptr;
        wr_nxt   = push ? ptr_inc(wr_ptr) : wr_ptr;
        cnt_nxt  = count;
        head_nxt = '0;

        if (push && !pop) begin
            cnt_nxt = count + CNT_W'(1);
        end else if (pop && !push) begin
            cnt_nxt = count - CNT_W'(1);
        end

        // The new head is the incoming beat when it lands in the head slot,
        // since storage is only written at the coming edge.
        if (cnt_nxt != '0) begin
            head_nxt = (push && (wr_ptr == rd_nxt)) ? in_ent : mem[rd_nxt];
        end

        if (flush) begin
            rd_nxt   = '0;
            wr_nxt   = '0;
            cnt_nxt  = '0;
            head_nxt = '0;
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            head_q    <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            rd_ptr    <= rd_nxt;
            wr_ptr    <= wr_nxt;
            count     <= cnt_nxt;
            out_valid <= (cnt_nxt != '0);
            head_q    <= head_nxt;
        end
    end

    // Beat storage, written on accepted pushes.
    // NOTE: storage has no reset; occupancy decides what is valid, so its content is don't-care.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_ent;
        end
    end

`ifndef SYNTHESIS
    // Push into a full buffer or pop from an empty one means the handshake logic is broken.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(push && (count == FULL)));
            assert (!(pop && (count == '0)));
        end
    end
`endif

endmodule
